// File: rtl/mem_txn_arbiter.sv
// Two-way arbiter between the fetch and load/store channels onto the mem_ctrl transaction port.
// Grant/start/stop/done pulses and read data are registered; stall, wdata and wnext are combinational.
module mem_txn_arbiter #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDR_WIDTH     = 25,
  parameter int LEN_WIDTH      = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      f_req,
  input  logic [ADDR_WIDTH-1:0]     f_addr,
  input  logic [LEN_WIDTH-1:0]      f_len,
  input  logic                      f_ready,
  output logic                      f_gnt,
  output logic [DATA_BUS_WIDTH-1:0] f_rdata,
  output logic                      f_rvalid,
  output logic                      f_done,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDR_WIDTH-1:0]     d_addr,
  input  logic [LEN_WIDTH-1:0]      d_len,
  input  logic [DATA_BUS_WIDTH-1:0] d_wdata,
  output logic                      d_gnt,
  output logic                      d_wnext,
  output logic [DATA_BUS_WIDTH-1:0] d_rdata,
  output logic                      d_rvalid,
  output logic                      d_done,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic                      mem_start_read,
  output logic                      mem_start_write,
  output logic                      mem_stall,
  output logic                      mem_stop,
  output logic [DATA_BUS_WIDTH-1:0] mem_wdata,
  input  logic                      mem_data_req,
  input  logic [DATA_BUS_WIDTH-1:0] mem_rdata,
  input  logic                      mem_data_ready,
  input  logic                      mem_idle
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_XFER, S_STOP, S_WAIT} state_t;
  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t               state;
  logic                 owner;
  logic                 last_owner;
  logic                 we;
  logic [LEN_WIDTH-1:0] cnt;

  logic xfer_rd;
  logic xfer_wr;
  logic pick_d;
  logic beat;

  always_comb begin
    xfer_rd   = (state == S_XFER) && !we;
    xfer_wr   = (state == S_XFER) && we;
    // Load/store wins outright when alone, or on a tie when fetch went last.
    pick_d    = d_req && (!f_req || (last_owner == OWN_F));
    mem_stall = xfer_rd && (owner == OWN_F) && !f_ready;
    mem_wdata = xfer_wr ? d_wdata : '0;
    d_wnext   = xfer_wr && mem_data_req;
    beat      = (xfer_rd && mem_data_ready) || (xfer_wr && mem_data_req);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      owner           <= OWN_F;
      last_owner      <= OWN_F;
      we              <= 1'b0;
      cnt             <= '0;
      mem_addr        <= '0;
      f_gnt           <= 1'b0;
      d_gnt           <= 1'b0;
      f_done          <= 1'b0;
      d_done          <= 1'b0;
      f_rvalid        <= 1'b0;
      d_rvalid        <= 1'b0;
      f_rdata         <= '0;
      d_rdata         <= '0;
      mem_start_read  <= 1'b0;
      mem_start_write <= 1'b0;
      mem_stop        <= 1'b0;
    end else begin
      f_gnt           <= 1'b0;
      d_gnt           <= 1'b0;
      f_done          <= 1'b0;
      d_done          <= 1'b0;
      f_rvalid        <= 1'b0;
      d_rvalid        <= 1'b0;
      mem_start_read  <= 1'b0;
      mem_start_write <= 1'b0;
      mem_stop        <= 1'b0;

      case (state)
        S_IDLE: begin
          if (mem_idle && (f_req || d_req)) begin
            state <= S_START;
            owner <= pick_d;
            if (pick_d) begin
              we              <= d_we;
              mem_addr        <= d_addr;
              cnt             <= d_len;
              d_gnt           <= 1'b1;
              mem_start_write <= d_we;
              mem_start_read  <= !d_we;
            end else begin
              we             <= 1'b0;
              mem_addr       <= f_addr;
              cnt            <= f_len;
              f_gnt          <= 1'b1;
              mem_start_read <= 1'b1;
            end
          end
        end
        S_START: state <= S_XFER;
        S_XFER: begin
          if (xfer_rd && mem_data_ready) begin
            if (owner == OWN_F) begin
              f_rvalid <= 1'b1;
              f_rdata  <= mem_rdata;
            end else begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_rdata;
            end
          end
          if (beat) begin
            if (cnt == '0) begin
              mem_stop <= 1'b1;
              state    <= S_STOP;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        S_STOP: state <= S_WAIT;
        S_WAIT: begin
          if (mem_idle) begin
            f_done     <= (owner == OWN_F);
            d_done     <= (owner == OWN_D);
            last_owner <= owner;
            mem_addr   <= '0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_txn_arbiter.sv
// Directed bench for mem_txn_arbiter: tie-break, reads, write, stall, WAIT hold and mid-transfer reset.
module tb_mem_txn_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        f_req, f_ready, d_req, d_we;
  logic [24:0] f_addr, d_addr;
  logic [2:0]  f_len, d_len;
  logic [7:0]  d_wdata, mem_rdata;
  logic        mem_data_req, mem_data_ready, mem_idle;
  logic        f_gnt, f_rvalid, f_done, d_gnt, d_wnext, d_rvalid, d_done;
  logic [7:0]  f_rdata, d_rdata, mem_wdata;
  logic [24:0] mem_addr;
  logic        mem_start_read, mem_start_write, mem_stall, mem_stop;

  int checks = 0;
  int errors = 0;
  int nb;

  always #5 clock = ~clock;

  mem_txn_arbiter dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_len(f_len), .f_ready(f_ready),
    .f_gnt(f_gnt), .f_rdata(f_rdata), .f_rvalid(f_rvalid), .f_done(f_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_wnext(d_wnext), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_addr(mem_addr), .mem_start_read(mem_start_read), .mem_start_write(mem_start_write),
    .mem_stall(mem_stall), .mem_stop(mem_stop), .mem_wdata(mem_wdata),
    .mem_data_req(mem_data_req), .mem_rdata(mem_rdata), .mem_data_ready(mem_data_ready),
    .mem_idle(mem_idle)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    f_req = 0; f_ready = 1; f_addr = '0; f_len = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_len = '0; d_wdata = '0;
    mem_data_req = 0; mem_rdata = '0; mem_data_ready = 0; mem_idle = 1;
    tick(); tick();
    chk("rst_pulses", {f_gnt, d_gnt, mem_start_read, mem_start_write, mem_stop, f_done, d_done}, 0);
    chk("rst_rvalid", {f_rvalid, d_rvalid, mem_stall, d_wnext}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", {f_rdata, d_rdata, mem_wdata}, 0);
    reset = 1'b1;

    // Simultaneous requests: load/store wins the first tie.
    f_req = 1; f_addr = 25'h000100; f_len = 3;
    d_req = 1; d_we = 0; d_addr = 25'h000022; d_len = 0;
    tick();
    chk("tie_d_gnt", d_gnt, 1);
    chk("tie_f_gnt", f_gnt, 0);
    chk("tie_start_rd", mem_start_read, 1);
    chk("tie_addr", mem_addr, 25'h000022);
    tick();
    mem_data_ready = 1; mem_rdata = 8'h11;
    tick();
    chk("d_rd_vld", d_rvalid, 1);
    chk("d_rd_dat", d_rdata, 8'h11);
    chk("d_rd_fvld", f_rvalid, 0);
    chk("d_len0_stop", mem_stop, 1);
    mem_data_ready = 0;
    tick(); tick();
    chk("d_rd_done", d_done, 1);
    chk("d_rd_fdone", f_done, 0);

    // Both still requesting: fetch takes the next grant.
    tick();
    chk("rr_f_gnt", f_gnt, 1);
    chk("rr_d_gnt", d_gnt, 0);
    chk("rr_addr", mem_addr, 25'h000100);
    f_req = 0; d_req = 0;
    tick();
    chk("f_gnt_pulse", f_gnt, 0);
    chk("f_start_pulse", mem_start_read, 0);
    for (int i = 0; i < 4; i++) begin
      mem_data_ready = 1; mem_rdata = 8'hA0 + 8'(i);
      tick();
      chk("f_rd_vld", f_rvalid, 1);
      chk("f_rd_dat", f_rdata, 8'hA0 + 8'(i));
    end
    chk("f_stop", mem_stop, 1);

    // Memory stays busy in WAIT; a pending write must not be granted.
    mem_data_ready = 0; mem_idle = 0;
    d_req = 1; d_we = 1; d_addr = 25'h1ABCDE; d_len = 1; d_wdata = 8'h55;
    tick();
    chk("stop_pulse", mem_stop, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wait_no_done", f_done, 0);
      chk("wait_no_gnt", d_gnt, 0);
    end
    mem_idle = 1;
    tick();
    chk("wait_f_done", f_done, 1);
    chk("wait_still_no_gnt", d_gnt, 0);

    tick();
    chk("wr_gnt", d_gnt, 1);
    chk("wr_start", mem_start_write, 1);
    chk("wr_no_start_rd", mem_start_read, 0);
    chk("wr_addr", mem_addr, 25'h1ABCDE);
    d_req = 0;
    tick();
    mem_data_ready = 1; mem_data_req = 1;
    #1;
    chk("wr_wdata0", mem_wdata, 8'h55);
    chk("wr_wnext0", d_wnext, 1);
    tick();
    chk("wr_no_rvalid", d_rvalid, 0);
    d_wdata = 8'hAA;
    #1;
    chk("wr_wdata1", mem_wdata, 8'hAA);
    chk("wr_wnext1", d_wnext, 1);
    tick();
    chk("wr_stop", mem_stop, 1);
    mem_data_req = 0; mem_data_ready = 0;
    #1;
    chk("wr_wnext_off", d_wnext, 0);
    chk("wr_wdata_off", mem_wdata, 0);
    tick(); tick();
    chk("wr_done", d_done, 1);

    // Fetch of 8 bytes with the consumer not ready on transfer cycles 2-4.
    f_req = 1; f_addr = 25'h000200; f_len = 7; f_ready = 1;
    tick();
    chk("st_gnt", f_gnt, 1);
    f_req = 0;
    tick();
    nb = 0;
    for (int k = 0; k < 11; k++) begin
      f_ready = !(k >= 2 && k <= 4);
      mem_data_ready = f_ready;
      mem_rdata = 8'hB0 + 8'(nb);
      #1;
      chk("st_stall", mem_stall, (k >= 2 && k <= 4) ? 1 : 0);
      tick();
      if (k >= 2 && k <= 4) begin
        chk("st_no_vld", f_rvalid, 0);
      end else begin
        chk("st_vld", f_rvalid, 1);
        chk("st_dat", f_rdata, 8'hB0 + 8'(nb));
        nb++;
      end
    end
    chk("st_stop", mem_stop, 1);
    mem_data_ready = 0; f_ready = 1;
    tick(); tick();
    chk("st_done", f_done, 1);

    // Reset in the middle of a transfer.
    f_req = 1; f_addr = 25'h000300; f_len = 7;
    tick();
    f_req = 0;
    tick();
    mem_data_ready = 1; mem_rdata = 8'hC0;
    tick();
    chk("mr_vld", f_rvalid, 1);
    mem_data_ready = 0; f_ready = 0;
    #1;
    chk("mr_stall_pre", mem_stall, 1);
    reset = 0;
    #1;
    chk("mr_outs", {f_rvalid, mem_stall, mem_stop, f_done}, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_rdata", f_rdata, 0);
    tick(); tick();
    reset = 1; f_ready = 1;
    tick();
    chk("mr_no_done", {f_done, d_done}, 0);
    d_req = 1; d_we = 0; d_addr = 25'h000444; d_len = 0;
    tick();
    chk("mr_regnt", d_gnt, 1);
    chk("mr_regnt_start", mem_start_read, 1);
    chk("mr_regnt_addr", mem_addr, 25'h000444);
    d_req = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
